// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to NUM_BUS of NUM_REQ results per cycle and registers them
// onto the wakeup buses. Optional build macro CDB_LSQ_PRIORITY_EN pins the LSQ to bus 0.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_BUS = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned ROB_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_value,
  input  logic [NUM_REQ*ROB_W-1:0]  i_req_rob_index,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_BUS-1:0]        o_bus_valid,
  output logic [NUM_BUS*TAG_W-1:0]  o_bus_tag,
  output logic [NUM_BUS*DATA_W-1:0] o_bus_value,
  output logic [NUM_BUS*ROB_W-1:0]  o_bus_rob_index,
  output logic [NUM_BUS*2-1:0]      o_bus_src,
  output logic [15:0]               o_conflict_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);
`ifdef CDB_LSQ_PRIORITY_EN
  // The LSQ sits outside the rotation; the pointer only walks the FUs.
  localparam int unsigned RR_N = NUM_REQ - 1;
`else
  localparam int unsigned RR_N = NUM_REQ;
`endif

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [15:0]       r_conflict_count;
  logic [NUM_BUS-1:0] r_bus_valid;
  logic [TAG_W-1:0]  r_bus_tag   [NUM_BUS];
  logic [DATA_W-1:0] r_bus_value [NUM_BUS];
  logic [ROB_W-1:0]  r_bus_rob   [NUM_BUS];
  logic [1:0]        r_bus_src   [NUM_BUS];

  logic [TAG_W-1:0]  w_req_tag   [NUM_REQ];
  logic [DATA_W-1:0] w_req_value [NUM_REQ];
  logic [ROB_W-1:0]  w_req_rob   [NUM_REQ];

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_BUS-1:0] w_bus_gnt;
  logic [PTR_W-1:0]   w_bus_sel [NUM_BUS];
  logic               w_any_rr;
  logic [PTR_W-1:0]   w_last_rr;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_idx;
  int                 w_n_gnt;
  logic [PTR_W:0]     w_rr_sum;
  logic [PTR_W-1:0]   w_rr_next;
  logic [CNT_W-1:0]   w_popcnt;
  logic               w_conflict;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_req_tag[i]   = i_req_tag[i*TAG_W +: TAG_W];
    assign w_req_value[i] = i_req_value[i*DATA_W +: DATA_W];
    assign w_req_rob[i]   = i_req_rob_index[i*ROB_W +: ROB_W];
  end

  always_comb begin
    w_grant   = '0;
    w_bus_gnt = '0;
    for (int b = 0; b < int'(NUM_BUS); b++) begin
      w_bus_sel[b] = '0;
    end
    w_any_rr  = 1'b0;
    w_last_rr = '0;
    w_sum     = '0;
    w_idx     = '0;
    w_n_gnt   = 0;
`ifdef CDB_LSQ_PRIORITY_EN
    if (i_req_valid[NUM_REQ-1]) begin
      w_grant[NUM_REQ-1] = 1'b1;
      w_bus_gnt[0]       = 1'b1;
      w_bus_sel[0]       = PTR_W'(NUM_REQ - 1);
      w_n_gnt            = 1;
    end
`endif
    // Scan from the pointer with wrap-around; the n-th valid requester found takes bus n.
    for (int k = 0; k < int'(RR_N); k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(RR_N)) begin
        w_sum = w_sum - (PTR_W+1)'(RR_N);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_req_valid[w_idx] && (w_n_gnt < int'(NUM_BUS))) begin
        w_grant[w_idx] = 1'b1;
        for (int b = 0; b < int'(NUM_BUS); b++) begin
          if (w_n_gnt == b) begin
            w_bus_gnt[b] = 1'b1;
            w_bus_sel[b] = w_idx;
          end
        end
        w_n_gnt   = w_n_gnt + 1;
        w_any_rr  = 1'b1;
        w_last_rr = w_idx;
      end
    end
  end

  always_comb begin
    w_rr_sum = {1'b0, w_last_rr} + (PTR_W+1)'(1);
    if (w_rr_sum >= (PTR_W+1)'(RR_N)) begin
      w_rr_sum = '0;
    end
    w_rr_next = w_rr_sum[PTR_W-1:0];
  end

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_popcnt = w_popcnt + CNT_W'(i_req_valid[i]);
    end
  end

  assign w_conflict  = (32'(w_popcnt) > NUM_BUS);
  assign o_req_ready = w_grant & {NUM_REQ{i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr         <= '0;
      r_conflict_count <= '0;
    end else begin
      if (w_any_rr) begin
        r_rr_ptr <= w_rr_next;
      end
      if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
        r_conflict_count <= r_conflict_count + 16'd1;
      end
    end
  end

  // Idle buses keep their last payload; only the valid bit drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_valid <= '0;
      for (int b = 0; b < int'(NUM_BUS); b++) begin
        r_bus_tag[b]   <= '0;
        r_bus_value[b] <= '0;
        r_bus_rob[b]   <= '0;
        r_bus_src[b]   <= '0;
      end
    end else begin
      r_bus_valid <= w_bus_gnt;
      for (int b = 0; b < int'(NUM_BUS); b++) begin
        if (w_bus_gnt[b]) begin
          r_bus_tag[b]   <= w_req_tag[w_bus_sel[b]];
          r_bus_value[b] <= w_req_value[w_bus_sel[b]];
          r_bus_rob[b]   <= w_req_rob[w_bus_sel[b]];
          r_bus_src[b]   <= 2'(w_bus_sel[b]);
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    assign o_bus_tag[b*TAG_W +: TAG_W]       = r_bus_tag[b];
    assign o_bus_value[b*DATA_W +: DATA_W]   = r_bus_value[b];
    assign o_bus_rob_index[b*ROB_W +: ROB_W] = r_bus_rob[b];
    assign o_bus_src[b*2 +: 2]               = r_bus_src[b];
  end

  assign o_bus_valid      = r_bus_valid;
  assign o_conflict_count = r_conflict_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-free reference model checked every cycle, plus literal
// expectations for reset, alternation, single request, wrap-around and saturation.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int NB = 2;
  localparam int TW = 6;
  localparam int RW = 6;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*TW-1:0]  req_tag;
  logic [NR*DW-1:0]  req_value;
  logic [NR*RW-1:0]  req_rob;
  logic [NR-1:0]     req_ready;
  logic [NB-1:0]     bus_valid;
  logic [NB*TW-1:0]  bus_tag;
  logic [NB*DW-1:0]  bus_value;
  logic [NB*RW-1:0]  bus_rob;
  logic [NB*2-1:0]   bus_src;
  logic [15:0]       conflict_count;

  int nvec  = 0;
  int nfail = 0;
  logic chk_en = 1'b0;

  // Reference model state
  int            m_ptr = 0;
  int            m_cnt = 0;
  logic [NR-1:0] m_gnt = '0;
  logic [NB-1:0] m_bv = '0;
  logic [TW-1:0] m_tag [NB];
  logic [DW-1:0] m_val [NB];
  logic [RW-1:0] m_rob [NB];
  int            m_src [NB];

  cdb_arbiter #(
    .NUM_REQ(NR), .NUM_BUS(NB), .TAG_W(TW), .ROB_W(RW), .DATA_W(DW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .i_req_tag        (req_tag),
    .i_req_value      (req_value),
    .i_req_rob_index  (req_rob),
    .o_req_ready      (req_ready),
    .o_bus_valid      (bus_valid),
    .o_bus_tag        (bus_tag),
    .o_bus_value      (bus_value),
    .o_bus_rob_index  (bus_rob),
    .o_bus_src        (bus_src),
    .o_conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Order of service: LSQ first when prioritised, then the rotation from ptr.
  function automatic void model_arb(input logic [NR-1:0] v, input int ptr,
                                    output logic [NR-1:0] gnt, output int sel [NB],
                                    output int ng, output int nptr);
    int rr_n = NR;
    gnt  = '0;
    ng   = 0;
    nptr = ptr;
    for (int b = 0; b < NB; b++) sel[b] = 0;
`ifdef CDB_LSQ_PRIORITY_EN
    rr_n = NR - 1;
    if (v[NR-1]) begin
      gnt[NR-1] = 1'b1;
      sel[0]    = NR - 1;
      ng        = 1;
    end
`endif
    for (int k = 0; k < rr_n; k++) begin
      int i;
      i = (ptr + k) % rr_n;
      if (v[i] && ng < NB) begin
        gnt[i]  = 1'b1;
        sel[ng] = i;
        ng++;
        nptr = (i + 1) % rr_n;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_p
    logic [NR-1:0] g;
    int s [NB];
    int n, np;
    if (!rst_n) begin
      m_ptr <= 0;
      m_cnt <= 0;
      m_gnt <= '0;
      m_bv  <= '0;
    end else begin
      model_arb(req_valid, m_ptr, g, s, n, np);
      m_ptr <= np;
      m_gnt <= g;
      if ($countones(req_valid) > NB && m_cnt < 65535) m_cnt <= m_cnt + 1;
      for (int b = 0; b < NB; b++) begin
        if (b < n) begin
          m_bv[b]  <= 1'b1;
          m_tag[b] <= req_tag[s[b]*TW +: TW];
          m_val[b] <= req_value[s[b]*DW +: DW];
          m_rob[b] <= req_rob[s[b]*RW +: RW];
          m_src[b] <= s[b];
        end else begin
          m_bv[b] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp_p
    logic [NR-1:0] g;
    int s [NB];
    int n, np;
    if (chk_en) begin
      model_arb(req_valid, m_ptr, g, s, n, np);
      chk("req_ready", 32'(req_ready), rst_n ? 32'(g) : 32'd0);
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("bus%0d_valid", b), 32'(bus_valid[b]), 32'(m_bv[b]));
        if (m_bv[b]) begin
          chk($sformatf("bus%0d_tag", b), 32'(bus_tag[b*TW +: TW]), 32'(m_tag[b]));
          chk($sformatf("bus%0d_value", b), bus_value[b*DW +: DW], m_val[b]);
          chk($sformatf("bus%0d_rob", b), 32'(bus_rob[b*RW +: RW]), 32'(m_rob[b]));
          chk($sformatf("bus%0d_src", b), 32'(bus_src[b*2 +: 2]), 32'(m_src[b]));
        end
      end
      chk("conflict_count", 32'(conflict_count), 32'(m_cnt));
    end
  end

  // Advance one cycle; granted requesters load fresh payloads, then apply the new valid set.
  task automatic step(input logic [NR-1:0] v);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (m_gnt[i]) begin
        req_tag[i*TW +: TW]   = TW'($urandom);
        req_value[i*DW +: DW] = $urandom;
        req_rob[i*RW +: RW]   = RW'($urandom);
      end
    end
    req_valid = v;
  endtask

  logic [NR-1:0] pat [8];

  initial begin
    pat = '{4'b0000, 4'b1010, 4'b0111, 4'b1110, 4'b0001, 4'b1111, 4'b0101, 4'b1000};
    rst_n     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_tag[i*TW +: TW]   = TW'($urandom);
      req_value[i*DW +: DW] = $urandom;
      req_rob[i*RW +: RW]   = RW'($urandom);
    end
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held with all requesters valid
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_conflict", 32'(conflict_count), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("rel_ready", 32'(req_ready), 32'b1001);
`else
    chk("rel_ready", 32'(req_ready), 32'b0011);
`endif

    step(4'b1111);
    @(negedge clk);
    chk("c1_bus_valid", 32'(bus_valid), 32'b11);
    chk("c1_conflict", 32'(conflict_count), 32'd1);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("c1_src", 32'(bus_src), 32'b0011);
    chk("c1_ready", 32'(req_ready), 32'b1010);
`else
    chk("c1_src", 32'(bus_src), 32'b0100);
    chk("c1_ready", 32'(req_ready), 32'b1100);
`endif

    step(4'b1111);
    @(negedge clk);
    chk("c2_conflict", 32'(conflict_count), 32'd2);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("c2_src", 32'(bus_src), 32'b0111);
    chk("c2_ready", 32'(req_ready), 32'b1100);
`else
    chk("c2_src", 32'(bus_src), 32'b1110);
    chk("c2_ready", 32'(req_ready), 32'b0011);
`endif

    // Single request from FU3
    step(4'b0100);
    req_tag[2*TW +: TW]   = 6'd17;
    req_value[2*DW +: DW] = 32'hDEADBEEF;
    req_rob[2*RW +: RW]   = 6'd5;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0100);
    chk("c3_conflict", 32'(conflict_count), 32'd3);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("c3_src", 32'(bus_src), 32'b1011);
`endif

    step(4'b1001);
    @(negedge clk);
    chk("single_bus_valid", 32'(bus_valid), 32'b01);
    chk("single_tag", 32'(bus_tag[TW-1:0]), 32'd17);
    chk("single_value", bus_value[DW-1:0], 32'hDEADBEEF);
    chk("single_rob", 32'(bus_rob[RW-1:0]), 32'd5);
    chk("single_src", 32'(bus_src[1:0]), 32'd2);
    chk("wrap_ready", 32'(req_ready), 32'b1001);

    step(4'b1111);
    @(negedge clk);
    chk("wrap_bus_valid", 32'(bus_valid), 32'b11);
    chk("wrap_src", 32'(bus_src), 32'b0011);
    chk("wrap_conflict", 32'(conflict_count), 32'd3);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("wrap_ptr_ready", 32'(req_ready), 32'b1010);
`else
    chk("wrap_ptr_ready", 32'(req_ready), 32'b0110);
`endif

    // Reset mid-operation drops in-flight broadcasts
    step(4'b1111);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bus_valid", 32'(bus_valid), 32'd0);
    chk("midrst_conflict", 32'(conflict_count), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
`ifdef CDB_LSQ_PRIORITY_EN
    chk("midrst_rel_ready", 32'(req_ready), 32'b1001);
`else
    chk("midrst_rel_ready", 32'(req_ready), 32'b0011);
`endif

    // Mixed directed patterns, checked by the model each cycle
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 8; p++) step(pat[p]);
    end

    // Saturation
    repeat (70000) step(4'b1111);
    @(negedge clk);
    chk("sat_conflict", 32'(conflict_count), 32'hFFFF);
    step(4'b1111);
    @(negedge clk);
    chk("sat_hold", 32'(conflict_count), 32'hFFFF);

    step(4'b0000);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
